// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester handshakes and memory port of the two-requester arbiter
interface mem_arbiter_if #(
  parameter int AW = 13,
  parameter int DW = 8
);
  logic req0, req1, we0, we1, gnt0, gnt1, ack0, ack1, mem_rd, mem_wr, busy;
  logic [AW-1:0] addr0, addr1, mem_addr;
  logic [DW-1:0] wdata0, wdata1, rdata, mem_wdata, mem_rdata;
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, ack0, ack1, rdata, mem_addr, mem_wdata, mem_rd, mem_wr, busy
  );
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, ack0, ack1, rdata, mem_addr, mem_wdata, mem_rd, mem_wr, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-requester arbiter driving wait-stated memory strobes
module mem_arbiter #(
  parameter int AW = 13,
  parameter int DW = 8,
  parameter int WAIT_CYC = 2
) (
  input logic clk,
  input logic reset,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
  state_t state, state_d;
  logic last, last_d, rd_d, wr_d, pick1;
  logic [1:0] gnt_d, ack_d;
  logic [3:0] cnt, cnt_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d, rdata_d;
  // on a tie the requester not served last wins
  assign pick1 = bus.req1 & (~bus.req0 | ~last);
  assign bus.busy = state != IDLE;
  always_comb begin
    state_d = state;
    last_d = last;
    cnt_d = cnt;
    gnt_d = {bus.gnt1, bus.gnt0};
    ack_d = 2'b00;
    rd_d = bus.mem_rd;
    wr_d = bus.mem_wr;
    addr_d = bus.mem_addr;
    wdata_d = bus.mem_wdata;
    rdata_d = bus.rdata;
    case (state)
      IDLE: if (bus.req0 | bus.req1) begin
        state_d = ACCESS;
        cnt_d = 4'(WAIT_CYC);
        gnt_d = pick1 ? 2'b10 : 2'b01;
        wr_d = pick1 ? bus.we1 : bus.we0;
        rd_d = ~wr_d;
        addr_d = pick1 ? bus.addr1 : bus.addr0;
        wdata_d = wr_d ? (pick1 ? bus.wdata1 : bus.wdata0) : '0;
      end
      ACCESS: if (cnt != 4'd0) cnt_d = cnt - 4'd1;
      else begin
        state_d = ACK;
        rd_d = 1'b0;
        wr_d = 1'b0;
        addr_d = '0;
        wdata_d = '0;
        rdata_d = bus.mem_rd ? bus.mem_rdata : bus.rdata;
        ack_d = {bus.gnt1, bus.gnt0};
        last_d = bus.gnt1;
      end
      default: begin
        state_d = IDLE;
        gnt_d = 2'b00;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last <= 1'b1;
      cnt <= '0;
      {bus.gnt1, bus.gnt0} <= 2'b00;
      {bus.ack1, bus.ack0} <= 2'b00;
      bus.mem_rd <= 1'b0;
      bus.mem_wr <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      bus.rdata <= '0;
    end else begin
      state <= state_d;
      last <= last_d;
      cnt <= cnt_d;
      {bus.gnt1, bus.gnt0} <= gnt_d;
      {bus.ack1, bus.ack0} <= ack_d;
      bus.mem_rd <= rd_d;
      bus.mem_wr <= wr_d;
      bus.mem_addr <= addr_d;
      bus.mem_wdata <= wdata_d;
      bus.rdata <= rdata_d;
    end
  end
endmodule
